stepper_motor_ctrl: RTL and testbench
=====================================

STEPPER_MOTOR_CTRL -- requirements
Module: stepper_motor_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DIV_W, 16, step-period divider width.
REQ-002 STEP_W, 16, step-count width per command.
REQ-003 POS_W, 24, signed position counter width.
REQ-004 Ports SHALL be (name, direction, width, meaning): system1000, in, 1, clock.
REQ-005 system1000_rst, in, 1, reset, synchronous, active-high.
REQ-006 en, in, 1, global enable; low freezes the divider and blocks steps.
REQ-007 cmd_valid, in, 1 / cmd_ready, out, 1: move-command handshake.
REQ-008 cmd_dir, in, 1 (1 = forward); cmd_half, in, 1 (1 = half-step, 0 = full-step); cmd_steps, in, STEP_W; cmd_period, in, DIV_W (clocks per step).
REQ-009 abort, in, 1; pos_load, in, 1; pos_load_val, in, POS_W.
REQ-010 position, out, POS_W; busy, out, 1; done, out, 1; step_pulse, out, 1; coils, out, 4 (registered).

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE; cmd_ready = (state == IDLE); busy = (state != IDLE).
REQ-012 On accept (cmd_valid && cmd_ready), dir, half, steps and period SHALL be latched, and cmd_period == 0 SHALL be treated as 1.
REQ-013 On accept with cmd_steps == 0, the FSM SHALL go to DONE with no motion.
REQ-014 On accept with cmd_steps != 0, the FSM SHALL go to RUN and load the divider with period-1.
REQ-015 In RUN with en = 1, the divider SHALL decrement each cycle; at 0 it SHALL issue a step tick and reload with period-1.
REQ-016 The first step tick SHALL occur exactly period cycles after the accept cycle when en stays high.
REQ-017 While en = 0, the divider and the FSM SHALL hold, and no step tick SHALL occur.
REQ-018 On a step tick, the following SHALL all update on the same edge: 3-bit phase, coils, position and remaining count; step_pulse SHALL be high for that one cycle.
REQ-019 Coil pattern by phase 0..7 SHALL be 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-020 Half-step: phase SHALL move ±1 mod 8 per tick and position ±1.
REQ-021 Full-step with odd phase: phase SHALL move ±2 mod 8 and position ±2.
REQ-022 Full-step with even phase: the tick SHALL move phase ±1 to align and position ±1.
REQ-023 Position SHALL wrap two's-complement modulo 2^POS_W.
REQ-024 When remaining count reaches 0 on a tick, the FSM SHALL go to DONE next.
REQ-025 DONE SHALL last exactly one cycle with done = 1, then return to IDLE.
REQ-026 abort high in RUN SHALL suppress any coincident step tick and go to DONE next cycle; abort in IDLE or DONE SHALL be ignored.
REQ-027 pos_load in IDLE SHALL set position to pos_load_val next cycle; in RUN or DONE it SHALL be ignored.
REQ-028 pos_load and an accept in the same IDLE cycle SHALL both take effect.

Reset
REQ-029 When system1000_rst is high at a clock edge, the block SHALL set state IDLE, phase 0, position 0, coils 0000, done 0, step_pulse 0 and divider 0.
REQ-030 cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-031 Reset SHALL override any operation in progress, including mid-RUN, with no done pulse.

Configuration
REQ-032 With macro STEPPER_MOTOR_CTRL_IDLE_RELEASE_EN defined, coils SHALL be 0000 whenever the FSM is in IDLE or en = 0.
REQ-033 In that case, on accept, coils SHALL be driven with pattern(phase) from the next cycle.
REQ-034 Without the macro, coils SHALL hold pattern(phase) in IDLE (holding torque) once any command has been accepted since reset, and SHALL be 0000 before that.
REQ-035 Without the macro, en = 0 SHALL NOT change coils.

Verification
REQ-036 Reset; half=1, dir=1, steps=3, period=4 -> step_pulse at accept+4, +8, +12; coils 1100, 0100, 0110; position 3; done at accept+13; cmd_ready at accept+14.
REQ-037 Phase 0, full-step, dir=0, steps=2, period=1 -> phases 7, 5; coils 1001, 0011; position -3 (all ones in low 24 bits).
REQ-038 steps=5, period=2, abort asserted at cycle of 3rd tick -> exactly 2 step_pulses, done next cycle, position 2.
REQ-039 pos_load_val=0x7FFFFF with an accept of half, dir=1, steps=1, period=1 -> position 0x800000 after tick; pos_load during RUN leaves position unchanged.
REQ-040 en low for 10 cycles mid-RUN, period=3 -> tick spacing stretched by exactly 10 cycles; coils 0000 during the stall only with the macro defined.
REQ-041 steps=0 accept -> done one cycle later with no step_pulse; reset mid-RUN -> coils 0000 and position 0 next cycle.

Source files
------------

// File: rtl/stepper_motor_ctrl.sv
// stepper_motor_ctrl: accepts move commands (direction, half/full step,
// step count, step period). It times steps with a reloadable divider and
// drives a 4-coil unipolar winding pattern from a 3-bit phase. It also keeps
// a signed position count.
//
// Optional build macro STEPPER_MOTOR_CTRL_IDLE_RELEASE_EN:
//   defined   -> coils are released (0000) in IDLE and whenever en is low.
//   undefined -> coils keep holding torque in IDLE once any command has run.
module stepper_motor_ctrl #(
    parameter int DIV_W  = 16,
    parameter int STEP_W = 16,
    parameter int POS_W  = 24
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    input  logic              en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic              cmd_half,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  cmd_period,
    input  logic              abort,
    input  logic              pos_load,
    input  logic [POS_W-1:0]  pos_load_val,
    output logic [POS_W-1:0]  position,
    output logic              busy,
    output logic              done,
    output logic              step_pulse,
    output logic [3:0]        coils
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              dir_q;
    logic              half_q;
    logic [STEP_W-1:0] steps_rem;
    logic [DIV_W-1:0]  period_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [2:0]        phase;
    logic [POS_W-1:0]  pos_q;
    logic [3:0]        coils_q;
    logic              engaged;

    logic              accept;
    logic [DIV_W-1:0]  period_eff;
    logic              tick;
    logic              two_step;
    logic [2:0]        phase_after;
    logic [POS_W-1:0]  pos_delta;
    logic [3:0]        coils_next;

    // Winding pattern for each of the eight half-step phases.
    function automatic logic [3:0] coil_pattern(input logic [2:0] p);
        logic [3:0] pat;
        case (p)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1100;
            3'd2:    pat = 4'b0100;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0010;
            3'd5:    pat = 4'b0011;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    assign accept     = cmd_valid && (state == IDLE);
    assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

    // A step fires when the divider has run out in RUN, unless en is low or abort wins.
    assign tick       = (state == RUN) && en && !abort && (div_cnt == '0);

    // Full-step from an odd phase jumps two phases; from an even phase it first aligns by one.
    assign two_step   = !half_q && phase[0];
    assign pos_delta  = two_step ? POS_W'(2) : POS_W'(1);

    // Phase after this cycle, used so coils track the phase in the same edge.
    always_comb begin
        phase_after = phase;
        if (tick) begin
            if (dir_q) begin
                phase_after = two_step ? (phase + 3'd2) : (phase + 3'd1);
            end else begin
                phase_after = two_step ? (phase - 3'd2) : (phase - 3'd1);
            end
        end
    end

    // Next-state decode and the handshake/status outputs.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        step_pulse = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    state_next = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                step_pulse = tick;
                if (abort) begin
                    state_next = DONE;
                end else if (tick && (steps_rem == STEP_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Coil drive for the next cycle, depending on whether idle release is built in.
    always_comb begin
        coils_next = 4'b0000;
`ifdef STEPPER_MOTOR_CTRL_IDLE_RELEASE_EN
        if ((state_next != IDLE) && en) begin
            coils_next = coil_pattern(phase_after);
        end
`else
        if (engaged || accept) begin
            coils_next = coil_pattern(phase_after);
        end
`endif
    end

    // State register.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command latch: direction, mode, period and remaining step count.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            dir_q     <= 1'b0;
            half_q    <= 1'b0;
            period_q  <= DIV_W'(1);
            steps_rem <= '0;
            engaged   <= 1'b0;
        end else if (accept) begin
            dir_q     <= cmd_dir;
            half_q    <= cmd_half;
            period_q  <= period_eff;
            steps_rem <= cmd_steps;
            engaged   <= 1'b1;
        end else if (tick) begin
            steps_rem <= steps_rem - STEP_W'(1);
        end
    end

    // Step-period divider: loaded on accept, counts down in RUN while enabled.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            div_cnt <= '0;
        end else if (accept) begin
            div_cnt <= period_eff - DIV_W'(1);
        end else if ((state == RUN) && en && !abort) begin
            if (div_cnt == '0) begin
                div_cnt <= period_q - DIV_W'(1);
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end

    // Phase, position and coil registers all move together on a step tick.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            phase   <= 3'd0;
            pos_q   <= '0;
            coils_q <= 4'b0000;
        end else begin
            phase   <= phase_after;
            coils_q <= coils_next;
            if (tick) begin
                pos_q <= dir_q ? (pos_q + pos_delta) : (pos_q - pos_delta);
            end else if ((state == IDLE) && pos_load) begin
                pos_q <= pos_load_val;
            end
        end
    end

    assign position = pos_q;
    assign coils    = coils_q;

endmodule

// File: tb/tb_stepper_motor_ctrl.sv
// Testbench for stepper_motor_ctrl. Stimulus pushes expected step pulses
// and done pulses into a queue. A monitor pops an entry each time the DUT
// shows step_pulse or done. It then checks the cycle, and on the next cycle
// it checks the coils and position.
module tb_stepper_motor_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic        cmd_half;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        pos_load;
    logic [23:0] pos_load_val;
    logic [23:0] position;
    logic        busy;
    logic        done;
    logic        step_pulse;
    logic [3:0]  coils;

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [3:0]  coils;
        logic [23:0] pos;
    } exp_t;

    exp_t exp_q[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    stepper_motor_ctrl #(.DIV_W(16), .STEP_W(16), .POS_W(24)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .en             (en),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_dir        (cmd_dir),
        .cmd_half       (cmd_half),
        .cmd_steps      (cmd_steps),
        .cmd_period     (cmd_period),
        .abort          (abort),
        .pos_load       (pos_load),
        .pos_load_val   (pos_load_val),
        .position       (position),
        .busy           (busy),
        .done           (done),
        .step_pulse     (step_pulse),
        .coils          (coils)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_pulse(input int c, input logic [3:0] co, input logic [23:0] p);
        exp_t e;
        e.is_done = 1'b0;
        e.cyc     = c;
        e.coils   = co;
        e.pos     = p;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int c);
        exp_t e;
        e.is_done = 1'b1;
        e.cyc     = c;
        e.coils   = 4'b0000;
        e.pos     = 24'h0;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every step_pulse/done, checks post-tick state a cycle later.
    initial begin
        bit          pend;
        logic [3:0]  pend_coils;
        logic [23:0] pend_pos;
        exp_t        e;
        pend = 1'b0;
        pend_coils = 4'b0;
        pend_pos = 24'h0;
        forever begin
            @(negedge clk);
            if (pend) begin
                check_output("tick_coils", 32'(coils), 32'(pend_coils));
                check_output("tick_position", 32'(position), 32'(pend_pos));
                pend = 1'b0;
            end
            if (step_pulse) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_pulse", 32'(step_pulse), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("pulse_kind", 32'(e.is_done), 32'd0);
                    check_output("pulse_cycle", cyc, e.cyc);
                    pend       = 1'b1;
                    pend_coils = e.coils;
                    pend_pos   = e.pos;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("done_kind", 32'(e.is_done), 32'd1);
                    check_output("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 1000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cmd_ready) check_output("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        pos_load  = 1'b0;
        en        = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issues one command when the DUT is ready; acc returns the accept cycle.
    task automatic apply_stimulus(input logic d, input logic h, input int steps, input int period, output int acc);
        wait_idle();
        cmd_dir    = d;
        cmd_half   = h;
        cmd_steps  = 16'(steps);
        cmd_period = 16'(period);
        cmd_valid  = 1'b1;
        acc        = cyc;
        tick();
        cmd_valid  = 1'b0;
    endtask

    // Watchdog so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        rst          = 1'b1;
        en           = 1'b1;
        cmd_valid    = 1'b0;
        cmd_dir      = 1'b0;
        cmd_half     = 1'b0;
        cmd_steps    = 16'd0;
        cmd_period   = 16'd0;
        abort        = 1'b0;
        pos_load     = 1'b0;
        pos_load_val = 24'h0;

        // Reset state and half-step forward, 3 steps every 4 clocks.
        do_reset();
        check_output("reset_ready", 32'(cmd_ready), 32'd1);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_coils", 32'(coils), 32'd0);
        check_output("reset_position", 32'(position), 32'd0);
        check_output("reset_pulse", 32'(step_pulse), 32'd0);
        apply_stimulus(1'b1, 1'b1, 3, 4, acc);
        push_pulse(acc + 4, 4'b1100, 24'd1);
        push_pulse(acc + 8, 4'b0100, 24'd2);
        push_pulse(acc + 12, 4'b0110, 24'd3);
        push_done(acc + 13);
        wait_cycle(acc + 13);
        check_output("ready_in_done", 32'(cmd_ready), 32'd0);
        tick();
        check_output("ready_after_done", 32'(cmd_ready), 32'd1);
        check_output("t1_position", 32'(position), 32'd3);
`ifdef STEPPER_MOTOR_CTRL_IDLE_RELEASE_EN
        check_output("t1_idle_coils", 32'(coils), 32'b0000);
`else
        check_output("t1_idle_coils", 32'(coils), 32'b0110);
`endif

        // Full-step reverse from phase 0: align to 7, then jump to 5.
        do_reset();
        apply_stimulus(1'b0, 1'b0, 2, 1, acc);
        push_pulse(acc + 1, 4'b1001, 24'hFFFFFF);
        push_pulse(acc + 2, 4'b0011, 24'hFFFFFD);
        push_done(acc + 3);
        wait_idle();
        check_output("t2_position", 32'(position), 32'h00FFFFFD);

        // Abort coincident with the third tick suppresses it.
        do_reset();
        apply_stimulus(1'b1, 1'b1, 5, 2, acc);
        push_pulse(acc + 2, 4'b1100, 24'd1);
        push_pulse(acc + 4, 4'b0100, 24'd2);
        push_done(acc + 7);
        wait_cycle(acc + 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle();
        check_output("t3_position", 32'(position), 32'd2);

        // pos_load with accept in the same cycle, wrap to 0x800000, load ignored in RUN/DONE.
        wait_idle();
        pos_load     = 1'b1;
        pos_load_val = 24'h7FFFFF;
        cmd_dir      = 1'b1;
        cmd_half     = 1'b1;
        cmd_steps    = 16'd1;
        cmd_period   = 16'd1;
        cmd_valid    = 1'b1;
        acc          = cyc;
        push_pulse(acc + 1, 4'b0110, 24'h800000);
        push_done(acc + 2);
        tick();
        cmd_valid    = 1'b0;
        pos_load_val = 24'h123456;
        tick();
        tick();
        pos_load     = 1'b0;
        check_output("t4_ready", 32'(cmd_ready), 32'd1);
        check_output("t4_position", 32'(position), 32'h00800000);

        // en low for 10 cycles stretches tick spacing by exactly 10.
        apply_stimulus(1'b1, 1'b1, 2, 3, acc);
        push_pulse(acc + 3, 4'b0010, 24'h800001);
        push_pulse(acc + 16, 4'b0011, 24'h800002);
        push_done(acc + 17);
        wait_cycle(acc + 4);
        en = 1'b0;
        wait_cycle(acc + 8);
        check_output("stall_busy", 32'(busy), 32'd1);
`ifdef STEPPER_MOTOR_CTRL_IDLE_RELEASE_EN
        check_output("stall_coils", 32'(coils), 32'b0000);
`else
        check_output("stall_coils", 32'(coils), 32'b0010);
`endif
        wait_cycle(acc + 14);
        en = 1'b1;
        wait_idle();

        // Zero-step command: done next cycle with no motion.
        apply_stimulus(1'b1, 1'b1, 0, 3, acc);
        push_done(acc + 1);
        wait_idle();
        check_output("t6_position", 32'(position), 32'h00800002);

        // Zero period behaves as one clock per step.
        apply_stimulus(1'b1, 1'b1, 1, 0, acc);
        push_pulse(acc + 1, 4'b0001, 24'h800003);
        push_done(acc + 2);
        wait_idle();

        // Abort while idle is ignored: position and readiness unchanged.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("idle_abort_ready", 32'(cmd_ready), 32'd1);
        check_output("idle_abort_pos", 32'(position), 32'h00800003);

        // Reset in the middle of RUN: no done, everything cleared.
        apply_stimulus(1'b1, 1'b1, 4, 2, acc);
        push_pulse(acc + 2, 4'b1001, 24'h800004);
        wait_cycle(acc + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("midrun_rst_coils", 32'(coils), 32'd0);
        check_output("midrun_rst_position", 32'(position), 32'd0);
        check_output("midrun_rst_ready", 32'(cmd_ready), 32'd1);
        check_output("midrun_rst_busy", 32'(busy), 32'd0);

        repeat (6) tick();
        check_output("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
